// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity-sense constants
// and the bit-counter width helper used by the receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BRK    = 3'd5
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_sync_vote.sv
// 2-flop rx synchroniser plus 3-sample majority voter.
// Ports: clock, reset, rx in; sample strobe in; rx_s, vote out.
module uart_rx_sync_vote (
  input  logic clock,
  input  logic reset,
  input  logic rx,
  input  logic sample,
  output logic rx_s,
  output logic vote
);

  logic       sync1;
  logic       sync2;
  logic [1:0] hist;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 2'b11;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      if (sample)
        hist <= {hist[0], sync2};
    end
  end

  assign rx_s = sync2;

  // Two stored samples (M-1, M) plus the live one at M+1.
  assign vote = (hist[1] & hist[0]) |
                (hist[1] & sync2) |
                (hist[0] & sync2);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with majority voting, break handling and
// a valid/ready holding register. Optional parity: UART_RX_PARITY_EN.
// Ports: clock, reset, rx in; rx_data, rx_valid, frame_err, parity_err,
// overrun, busy out; rx_ready in.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int MC = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CW-1:0] C_LO  = CW'(MC - 1);
  localparam logic [CW-1:0] C_MID = CW'(MC);
  localparam logic [CW-1:0] C_HI  = CW'(MC + 1);
  localparam logic [CW-1:0] C_END = CW'(CLKS_PER_BIT - 1);

  localparam logic [3:0] LAST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam uart_state_e ST_AFTER_DATA = ST_PARITY;
  localparam logic PSENSE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
`else
  localparam uart_state_e ST_AFTER_DATA = ST_STOP;
`endif

  uart_state_e          state;
  logic [CW-1:0]        cnt;
  logic [3:0]           idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_err;
  logic                 par_q;
  logic                 par_held;

  logic rx_s;
  logic vote;
  logic in_frame;
  logic sample;
  logic decide;
  logic done;
  logic ferr_now;
  logic load;

  uart_rx_sync_vote u_sync (
    .clock  (clock),
    .reset  (reset),
    .rx     (rx),
    .sample (sample),
    .rx_s   (rx_s),
    .vote   (vote)
  );

  assign in_frame = (state == ST_START) ||
                    (state == ST_DATA) ||
                    (state == ST_PARITY) ||
                    (state == ST_STOP);

  assign sample   = in_frame && ((cnt == C_LO) || (cnt == C_MID));
  assign decide   = in_frame && (cnt == C_HI);
  assign done     = (state == ST_STOP) && decide && (idx == LAST_S);
  assign ferr_now = stop_err | ~vote;
  assign load     = done && (!rx_valid || rx_ready);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      stop_err  <= 1'b0;
      par_q     <= 1'b0;
      par_held  <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= done && rx_valid && !rx_ready;

      if (load) begin
        rx_data   <= shreg;
        frame_err <= ferr_now;
        par_held  <= par_q;
        rx_valid  <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end

      // Free-running bit timer inside a frame keeps every bit
      // boundary aligned to the start edge.
      cnt <= (cnt == C_END) ? '0 : cnt + CW'(1);

      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state    <= ST_START;
            idx      <= '0;
            stop_err <= 1'b0;
            par_q    <= 1'b0;
          end
        end
        ST_START: begin
          if (decide)
            state <= vote ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (decide) begin
            shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (idx == LAST_D) begin
              idx   <= '0;
              state <= ST_AFTER_DATA;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (decide) begin
            par_q <= ((^shreg) ^ vote) != PSENSE;
            state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (decide) begin
            stop_err <= ferr_now;
            if (idx == LAST_S) begin
              // Leave at mid-bit so a back-to-back start is caught.
              if (ferr_now && (shreg == '0)) begin
                state <= ST_BRK;
                cnt   <= '0;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        ST_BRK: begin
          // Needs one full bit time of continuous idle line.
          if (!rx_s)
            cnt <= '0;
          else if (cnt == C_END)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err = par_held;
`else
  logic unused_par;
  assign unused_par = par_held ^ par_q ^ PARITY_ODD[0];
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomised self-checking bench for uart_rx_cfg against a
// frame-level reference queue.
module tb_uart_rx_cfg;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int DB  = 7;
  localparam int SB  = 2;
  localparam bit PAR = 1'b1;
`else
  localparam int DB  = 8;
  localparam int SB  = 1;
  localparam bit PAR = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          rx;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;
  int ovr_cnt = 0;

  logic [31:0] got[$];
  logic [31:0] exp_q[$];

  uart_rx_cfg #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .STOP_BITS    (SB),
    .PARITY_ODD   (0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset && rx_valid && rx_ready)
      got.push_back({22'd0, parity_err, frame_err, 8'(rx_data)});
    if (!reset && overrun)
      ovr_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] req);
    n_cmp++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic hold(input logic b);
    rx = b;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic idle(input int bits);
    rx = 1'b1;
    repeat (bits * CPB) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [8:0] d,
                      input bit bad_stop,
                      input bit bad_par,
                      input int gap,
                      input bit expect_it,
                      input bit chk_lat);
    logic [8:0] dm;
    logic       pb;
    dm = d & ((9'd1 << DB) - 9'd1);
    pb = (^dm) ^ bad_par;
    rx = 1'b0;
    if (chk_lat) begin
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("busy_lat2", 32'(busy), 0);
      @(posedge clock);
      @(negedge clock);
      chk("busy_lat3", 32'(busy), 1);
      repeat (CPB - 3) @(posedge clock);
      #1;
    end else begin
      repeat (CPB) @(posedge clock);
      #1;
    end
    for (int i = 0; i < DB; i++)
      hold(dm[i]);
    if (PAR)
      hold(pb);
    for (int s = 0; s < SB; s++)
      hold((bad_stop && s == 0) ? 1'b0 : 1'b1);
    if (expect_it)
      exp_q.push_back({22'd0, PAR & bad_par, bad_stop, dm[7:0]});
    idle(gap);
  endtask

  task automatic drain(input string tag);
    repeat (3) @(posedge clock);
    #1;
    chk({tag, "_cnt"}, 32'(got.size()), 32'(exp_q.size()));
    while (got.size() > 0 && exp_q.size() > 0)
      chk(tag, got.pop_front(), exp_q.pop_front());
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int ovr0;
    reset    = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_perr", 32'(parity_err), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(2);

    send(9'h0A5, 0, 0, 2, 1, 1);
    drain("a5");

    rx = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    idle(3);
    chk("glitch_busy", 32'(busy), 0);
    drain("glitch");

    send(9'h03C, 1, 0, 2, 1, 0);
    send(9'h055, 0, 0, 2, 1, 0);
    drain("ferr");

    rx = 1'b0;
    repeat (30 * CPB) @(posedge clock);
    #1;
    exp_q.push_back({22'd0, 1'b0, 1'b1, 8'h00});
    idle(2);
    chk("brk_busy", 32'(busy), 0);
    send(9'h081, 0, 0, 2, 1, 0);
    drain("brk");

    ovr0 = ovr_cnt;
    rx_ready = 1'b0;
    send(9'h011, 0, 0, 0, 0, 0);
    send(9'h022, 0, 0, 2, 0, 0);
    @(negedge clock);
    chk("ovr_valid", 32'(rx_valid), 1);
    chk("ovr_data", 32'(rx_data), 32'h11);
    chk("ovr_pulses", 32'(ovr_cnt - ovr0), 1);
    @(posedge clock);
    #1;
    rx_ready = 1'b1;
    exp_q.push_back({22'd0, 1'b0, 1'b0, 8'h11});
    drain("ovr");

    if (PAR) begin
      send(9'h041, 0, 0, 2, 1, 0);
      send(9'h041, 0, 1, 2, 1, 0);
      drain("par");
    end

    rx_ready = 1'b0;
    send(9'h05A, 0, 0, 2, 0, 0);
    chk("pre_rst_valid", 32'(rx_valid), 1);
    rx = 1'b0;
    repeat (CPB) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++)
      hold(1'b1);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("mid_rst_valid", 32'(rx_valid), 0);
    chk("mid_rst_data", 32'(rx_data), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ferr", 32'(frame_err), 0);
    chk("mid_rst_perr", 32'(parity_err), 0);
    @(posedge clock);
    #1;
    rx       = 1'b1;
    reset    = 1'b0;
    rx_ready = 1'b1;
    idle(2);
    send(9'h06B, 0, 0, 2, 1, 0);
    drain("post_rst");

    ovr0 = ovr_cnt;
    for (int k = 0; k < 24; k++) begin
      logic [8:0] d;
      bit         bs;
      bit         bp;
      int         gap;
      d   = 9'($urandom_range(0, (1 << DB) - 1));
      bs  = ($urandom_range(0, 3) == 0);
      bp  = PAR ? bit'($urandom_range(0, 1)) : 1'b0;
      gap = bs ? 2 : $urandom_range(0, 2);
      send(d, bs, bp, gap, 1, 0);
    end
    idle(1);
    drain("rand");
    chk("rand_no_ovr", 32'(ovr_cnt - ovr0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver: configurable data width, stop-bit count and optional parity, with 3-sample majority voting, error reporting and a valid/ready output holding register. It sits between the asynchronous `rx` pin and a byte consumer (FIFO or command parser) in the serial host-link path. It replaces fixed 8N1 reception wherever framing must be configurable or errors must be visible.

## Interface
- `CLKS_PER_BIT`, 434; clock cycles per bit; legal range 8..4095.
- `DATA_BITS`, 8; data bits per frame, LSB first; legal range 5..9.
- `STOP_BITS`, 1; stop bits checked, 1 or 2.
- `PARITY_ODD`, 0; 1 = odd parity, 0 = even; used only with `UART_RX_PARITY_EN`.

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-high
- `rx`  in  1  asynchronous serial line, idle high
- `rx_data`  out  DATA_BITS  received word, stable while `rx_valid`=1
- `rx_valid`  out  1  word plus flags held for consumer
- `rx_ready`  in  1  consumer accepts; transfer when `rx_valid & rx_ready`
- `frame_err`  out  1  qualified by `rx_valid`: a stop bit sampled 0
- `parity_err`  out  1  qualified by `rx_valid`: parity mismatch; tied 0 without macro
- `overrun`  out  1  one-cycle pulse: completed word dropped, holder full
- `busy`  out  1  FSM not in IDLE

## Operation
- Input path: 2-flop synchroniser, both flops reset to 1. The FSM sees `rx_s`.
- Bit counter: width `$clog2(CLKS_PER_BIT)`. It clears on every bit boundary and on entry to START.
- Mid-bit sampling: the bit value is the majority of `rx_s` at counts M-1, M, M+1, where M = (CLKS_PER_BIT-1)/2. The decision is made at count M+1.
- FSM states:
  - IDLE: `rx_s`=0 → START.
  - START: voted 0 → DATA; voted 1 → IDLE (glitch rejected). The counter continues so bit boundaries stay aligned to the start edge.
  - DATA: shifts `DATA_BITS` voted bits into the shift register LSB first, then → PARITY if the macro is defined, else → STOP.
  - PARITY: compares the voted bit with the computed parity, then → STOP.
  - STOP: evaluates `STOP_BITS` stop bits. Leaves at the mid-bit decision of the last stop bit, not at the bit end, to allow back-to-back frames.
  - Exit from STOP: if any stop bit voted 0 and the data is all zero (break), → BRK; else → IDLE.
  - BRK: waits for `rx_s`=1 for one full bit time, then → IDLE.
- Completion (the cycle the last stop decision is made):
  - Holder empty, or being emptied this cycle (`rx_ready`=1): load `rx_data`/`frame_err`/`parity_err`; `rx_valid`=1 next cycle.
  - Otherwise: the word is discarded, the holder is unchanged, and `overrun` pulses one cycle.
- Frames with a framing error are still delivered, with `frame_err`=1. A break is also delivered once, as all-zero data with `frame_err`=1.
- `rx_valid` clears the cycle after a transfer. A simultaneous transfer and new load keeps `rx_valid`=1 with the new word.

## Timing
- Reset values:
  - `rx_valid`, `frame_err`, `parity_err`, `overrun`, `busy`: 0.
  - `rx_data`: 0.
  - FSM: IDLE; counters: 0; synchroniser: 1.
- Reset mid-frame abandons the frame and discards any held word. Reception resumes on the next falling edge after reset deasserts.
- Latency:
  - `rx` falling edge → `busy`=1: 3 cycles (2 sync cycles + 1 register).
  - Last stop bit mid-sample → `rx_valid`: 1 cycle.
- Flags change only when a word is loaded. `overrun` is independent of `rx_valid`.
- No combinational path from `rx_ready` to any output.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state exists; one parity bit follows the data.
  - `parity_err` is set when XOR(data, received parity bit) ≠ `PARITY_ODD`.
- Not defined:
  - No PARITY state and no parity logic; the frame is start + data + stop.
  - `parity_err` is constant 0; `PARITY_ODD` is ignored.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP, BRK).
  - Helper constant function for counter width.
  - Parity-sense constants shared with the transmitter.
- Sub-module `uart_rx_sync_vote` holds the 2-flop synchroniser and the 3-sample majority register. It outputs `rx_s` and the voted bit, and takes the sample strobe from the FSM.
- The FSM, shift register and output holder stay in the top module.

## Test plan
All scenarios use CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1, `rx_ready`=1 unless stated.

- Frame 0xA5 (8N1) → `rx_valid` pulses one cycle with `rx_data`=0xA5, `frame_err`=0, `parity_err`=0.
- 4-cycle low glitch on idle `rx` → FSM returns to IDLE; `rx_valid` never asserts.
- Frame 0x3C with stop bit forced 0 → `rx_data`=0x3C with `frame_err`=1. Next frame 0x55 is received clean.
- Line held low for 30 bit times, then released → exactly one word 0x00 with `frame_err`=1. No further words until the line has been high one bit time; then frame 0x81 is received correctly.
- `rx_ready`=0, send 0x11 then 0x22 back-to-back → holder keeps 0x11 and `overrun` pulses once at the end of 0x22. After raising `rx_ready`, one transfer of 0x11 occurs.
- With `UART_RX_PARITY_EN`, PARITY_ODD=0, DATA_BITS=7, STOP_BITS=2:
  - Frame 0x41 with parity bit 0 → `parity_err`=0.
  - The same frame with parity bit 1 → `parity_err`=1.
  - Assert `reset` mid-data → all outputs 0, then the next frame is received correctly.
